// File: rtl/tmm_tile_sequencer.sv
// Tile sequencer for the ternary systolic matmul array: beat counting, copy/clear strobes, streaming readout.
// Optional TMM_SEQ_NO_OVERRUN_EN holds the last beat of a tile so a copy never lands on an active readout.
module tmm_tile_sequencer #(
  parameter int ARRAY_SIZE = 4,
  parameter int K_BITS     = 8,
  parameter int PIPE_LAT   = 2,
  localparam int IDX_W     = (ARRAY_SIZE > 1) ? $clog2(ARRAY_SIZE) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [K_BITS-1:0] cfg_k,
  input  logic              start,
  output logic              start_ready,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              weight_gate,
  output logic              acc_reset,
  output logic              acc_copy,
  output logic              queue_restart,
  output logic              out_valid,
  output logic [IDX_W-1:0]  out_index,
  output logic              out_last,
  output logic              busy,
  output logic              overrun
);

  typedef enum logic {S_IDLE, S_LOAD} state_e;

  state_e              state_q;
  logic [K_BITS-1:0]   k_q, beat_cnt_q;
  logic [PIPE_LAT-1:0] tok_q;
  logic                rd_active_q;
  logic [IDX_W-1:0]    rd_idx_q;

  logic last_beat, hold_last, fire, fire_last, copy;

  // k_q - 1 wraps to all-ones when cfg_k was 0, giving the full 2^K_BITS beats.
  assign last_beat = (beat_cnt_q == k_q - K_BITS'(1));

`ifdef TMM_SEQ_NO_OVERRUN_EN
  int rd_rem;
  always_comb begin
    rd_rem    = ARRAY_SIZE - int'(rd_idx_q);
    // A token still in flight means a readout is about to start, so that blocks too.
    hold_last = (state_q == S_LOAD) && last_beat &&
                ((|tok_q) || (rd_active_q && (rd_rem > PIPE_LAT)));
  end
`else
  assign hold_last = 1'b0;
`endif

  assign in_ready      = (state_q == S_LOAD) && !hold_last;
  assign fire          = in_valid && in_ready;
  assign fire_last     = fire && last_beat;
  assign copy          = tok_q[PIPE_LAT-1];
  assign start_ready   = (state_q == S_IDLE);
  assign weight_gate   = !fire;
  assign acc_copy      = copy;
  assign acc_reset     = copy;
  assign queue_restart = copy;
  assign out_valid     = rd_active_q;
  assign out_index     = rd_idx_q;
  assign out_last      = rd_active_q && (rd_idx_q == IDX_W'(ARRAY_SIZE - 1));
  assign busy          = (state_q == S_LOAD) || (|tok_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      k_q         <= '0;
      beat_cnt_q  <= '0;
      tok_q       <= '0;
      rd_active_q <= 1'b0;
      rd_idx_q    <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start) begin
          state_q    <= S_LOAD;
          k_q        <= cfg_k;
          beat_cnt_q <= '0;
        end
        S_LOAD: if (fire) begin
          if (last_beat) begin
            beat_cnt_q <= '0;
            if (start) k_q <= cfg_k;
            else       state_q <= S_IDLE;
          end else begin
            beat_cnt_q <= beat_cnt_q + K_BITS'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase

      for (int i = PIPE_LAT - 1; i > 0; i--) tok_q[i] <= tok_q[i-1];
      tok_q[0] <= fire_last;

      // A fresh copy always wins and restarts the readout from entry 0.
      if (copy) begin
        rd_active_q <= 1'b1;
        rd_idx_q    <= '0;
      end else if (rd_active_q) begin
        if (rd_idx_q == IDX_W'(ARRAY_SIZE - 1)) begin
          rd_active_q <= 1'b0;
          rd_idx_q    <= '0;
        end else begin
          rd_idx_q <= rd_idx_q + IDX_W'(1);
        end
      end
    end
  end

`ifdef TMM_SEQ_NO_OVERRUN_EN
  assign overrun = 1'b0;
`else
  logic overrun_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                      overrun_q <= 1'b0;
    else if (copy && rd_active_q)   overrun_q <= 1'b1;
  end
  assign overrun = overrun_q;
`endif

endmodule

// File: tb/tb_tmm_tile_sequencer.sv
// Scoreboard bench for tmm_tile_sequencer: stimulus queues expected copy/readout events, a monitor checks them.
// Runs with K_BITS=4 so the cfg_k=0 (16-beat) case stays short.
module tb_tmm_tile_sequencer;
  localparam int AS = 4;
  localparam int KB = 4;
  localparam int PL = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [KB-1:0] cfg_k = '0;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic          start_ready, in_ready, weight_gate, acc_reset, acc_copy, queue_restart;
  logic          out_valid, out_last, busy, overrun;
  logic [1:0]    out_index;

  tmm_tile_sequencer #(.ARRAY_SIZE(AS), .K_BITS(KB), .PIPE_LAT(PL)) dut (
    .clk(clk), .reset(reset), .cfg_k(cfg_k), .start(start), .start_ready(start_ready),
    .in_valid(in_valid), .in_ready(in_ready), .weight_gate(weight_gate),
    .acc_reset(acc_reset), .acc_copy(acc_copy), .queue_restart(queue_restart),
    .out_valid(out_valid), .out_index(out_index), .out_last(out_last),
    .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic is_copy;
    int   cyc;
    int   idx;
    int   last;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_copy(input int c);
    exp_t e;
    e.is_copy = 1'b1; e.cyc = c; e.idx = 0; e.last = 0;
    sb.push_back(e);
  endtask

  task automatic push_out(input int c, input int i);
    exp_t e;
    e.is_copy = 1'b0; e.cyc = c; e.idx = i; e.last = (i == AS - 1) ? 1 : 0;
    sb.push_back(e);
  endtask

  task automatic push_readout(input int c);
    for (int i = 0; i < AS; i++) push_out(c + i, i);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  // Monitor: every strobe or readout beat must match the head of the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      if (acc_copy || acc_reset || queue_restart) begin
        if (sb.size() == 0 || !sb[0].is_copy) chk("copy_unexpected", cyc, -1);
        else begin
          e = sb.pop_front();
          chk("copy_cycle", cyc, e.cyc);
          chk("copy_strobes", int'({acc_copy, acc_reset, queue_restart}), 7);
        end
      end
      if (out_valid) begin
        if (sb.size() == 0 || sb[0].is_copy) chk("out_unexpected", cyc, -1);
        else begin
          e = sb.pop_front();
          chk("out_cycle", cyc, e.cyc);
          chk("out_index", int'(out_index), e.idx);
          chk("out_last", int'(out_last), e.last);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int beats;
    int seen;

    // Reset values while reset is held from time zero.
    #1;
    chk("rst_start_ready", int'(start_ready), 1);
    chk("rst_weight_gate", int'(weight_gate), 1);
    chk("rst_out_index", int'(out_index), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_others", int'({in_ready, acc_copy, acc_reset, queue_restart, out_valid, out_last, busy}), 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset mid-LOAD: cfg_k=5, two beats in, then async reset.
    tick(); start = 1; cfg_k = 4'd5;
    tick(); start = 0; in_valid = 1;
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    chk("midrst_start_ready", int'(start_ready), 1);
    chk("midrst_weight_gate", int'(weight_gate), 1);
    chk("midrst_in_ready", int'(in_ready), 0);
    chk("midrst_busy", int'(busy), 0);
    tick(); reset = 1'b0; in_valid = 0;
    repeat (8) tick();
    samp();
    chk("midrst_idle_start_ready", int'(start_ready), 1);

    // Test A: cfg_k=3, continuous beats: copy at +5, readout +6..+9.
    tick(); c0 = cyc; start = 1; cfg_k = 4'd3;
    push_copy(c0 + 5); push_readout(c0 + 6);
    samp(); chk("A_start_ready", int'(start_ready), 1);
    for (int k = 1; k <= 3; k++) begin
      tick(); start = 0; in_valid = 1;
      samp();
      chk("A_in_ready", int'(in_ready), 1);
      chk("A_weight_gate", int'(weight_gate), 0);
    end
    tick(); in_valid = 0;
    samp();
    chk("A_in_ready_after", int'(in_ready), 0);
    chk("A_busy_tokens", int'(busy), 1);
    chk("A_gate_bubble", int'(weight_gate), 1);
    repeat (7) tick();
    samp(); chk("A_busy_done", int'(busy), 0);

    // Test B: bubble at +2, last beat at +4, copy at +6.
    tick(); c0 = cyc; start = 1; cfg_k = 4'd3;
    push_copy(c0 + 6); push_readout(c0 + 7);
    tick(); start = 0; in_valid = 1;
    tick(); in_valid = 0;
    samp();
    chk("B_gate_bubble", int'(weight_gate), 1);
    chk("B_in_ready", int'(in_ready), 1);
    tick(); in_valid = 1;
    tick();
    tick(); in_valid = 0;
    repeat (7) tick();

    // Test E: start accepted during a readout while the load FSM is idle.
    tick(); c0 = cyc; start = 1; cfg_k = 4'd1;
    push_copy(c0 + 3); push_readout(c0 + 4);
    push_copy(c0 + 10); push_readout(c0 + 11);
    tick(); start = 0; in_valid = 1;
    tick(); in_valid = 0;
    tick();
    tick();
    tick(); start = 1; cfg_k = 4'd3;
    samp();
    chk("E_start_ready_in_read", int'(start_ready), 1);
    chk("E_reading", int'(out_valid), 1);
    tick(); start = 0; in_valid = 1;
    samp(); chk("E_in_ready_next", int'(in_ready), 1);
    tick();
    tick();
    tick(); in_valid = 0;
    repeat (7) tick();

    // Test D: cfg_k=0 means 2^K_BITS = 16 beats.
    tick(); c0 = cyc; start = 1; cfg_k = 4'd0;
    push_copy(c0 + 18); push_readout(c0 + 19);
    beats = 0; seen = 0;
    for (int n = 0; n < 40 && seen == 0; n++) begin
      tick(); start = 0; in_valid = 1;
      samp();
      if (in_valid && in_ready) beats++;
      if (acc_copy) seen = 1;
    end
    chk("D_copy_seen", seen, 1);
    chk("D_beats", beats, 16);
    in_valid = 0;
    repeat (7) tick();

    // Test C: back-to-back cfg_k=2 tiles, start high on the first last beat.
    tick(); c0 = cyc; start = 1; cfg_k = 4'd2;
`ifdef TMM_SEQ_NO_OVERRUN_EN
    push_copy(c0 + 4); push_readout(c0 + 5);
    push_copy(c0 + 9); push_readout(c0 + 10);
`else
    push_copy(c0 + 4); push_out(c0 + 5, 0);
    push_copy(c0 + 6); push_out(c0 + 6, 1);
    push_readout(c0 + 7);
`endif
    samp(); chk("C_overrun_before", int'(overrun), 0);
    tick(); start = 0; in_valid = 1;
    tick(); start = 1; cfg_k = 4'd2;
    samp(); chk("C_in_ready_b2b", int'(in_ready), 1);
    tick(); start = 0;
`ifdef TMM_SEQ_NO_OVERRUN_EN
    for (int k = 4; k <= 6; k++) begin
      tick();
      samp(); chk("C_hold_last", int'(in_ready), 0);
    end
    tick();
    samp(); chk("C_release_last", int'(in_ready), 1);
    tick(); in_valid = 0;
    repeat (7) tick();
    samp(); chk("C_overrun_tied", int'(overrun), 0);
`else
    tick();
    tick(); in_valid = 0;
    tick();
    tick();
    samp(); chk("C_overrun_set", int'(overrun), 1);
    repeat (5) tick();
    samp(); chk("C_overrun_sticky", int'(overrun), 1);
`endif

    repeat (2) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
